// File: rtl/phase_timer_pkg.sv
// Shared types and default durations for the traffic-light phase timer.
package phase_timer_pkg;

   localparam logic [1:0] MODE_SHORT  = 2'b00;
   localparam logic [1:0] MODE_LONG   = 2'b01;
   localparam logic [1:0] MODE_YELLOW = 2'b10;
   localparam logic [1:0] MODE_CUSTOM = 2'b11;

   localparam int unsigned DEF_SHORT_CNT  = 7;
   localparam int unsigned DEF_LONG_CNT   = 31;
   localparam int unsigned DEF_YELLOW_CNT = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/phase_down_counter.sv
// CNT_W-bit down-counter with synchronous load, decrement enable and zero flag.
module phase_down_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] count_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/phase_timer.sv
// Phase-duration timer: FSM, duration select and sticky/pulse outputs.
// Optional periodic reload on expiry when PHASE_TIMER_AUTO_RELOAD_EN is defined.
module phase_timer
   import phase_timer_pkg::*;
#(
   parameter int          CNT_W      = 8,
   parameter int unsigned SHORT_CNT  = DEF_SHORT_CNT,
   parameter int unsigned LONG_CNT   = DEF_LONG_CNT,
   parameter int unsigned YELLOW_CNT = DEF_YELLOW_CNT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             st,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] load_val,
   input  logic             hold,
   output logic             y,
   output logic             done_pulse,
   output logic             busy,
   output logic [CNT_W-1:0] count
);

   if (CNT_W < 2) begin : g_width_chk
      $error("phase_timer: CNT_W must be at least 2");
   end

   if (((SHORT_CNT >> CNT_W) != 0) || ((LONG_CNT >> CNT_W) != 0) ||
       ((YELLOW_CNT >> CNT_W) != 0)) begin : g_trunc_chk
      $warning("phase_timer: duration parameter truncated to CNT_W bits");
   end

   localparam logic [CNT_W-1:0] SHORT_T  = CNT_W'(SHORT_CNT);
   localparam logic [CNT_W-1:0] LONG_T   = CNT_W'(LONG_CNT);
   localparam logic [CNT_W-1:0] YELLOW_T = CNT_W'(YELLOW_CNT);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] term_q, term_d;
   logic             y_q, y_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] sel_term;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt_load_val;

   always_comb begin
      case (mode)
         MODE_SHORT:  sel_term = SHORT_T;
         MODE_LONG:   sel_term = LONG_T;
         MODE_YELLOW: sel_term = YELLOW_T;
         default:     sel_term = load_val;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      term_d       = term_q;
      y_d          = y_q;
      done_d       = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = term_q;
      cnt_dec      = 1'b0;
      if (st) begin
         term_d       = sel_term;
         cnt_load     = 1'b1;
         cnt_load_val = sel_term;
         y_d          = 1'b0;
         state_d      = ST_RUN;
      end else if (state_q == ST_RUN && !hold) begin
         if (cnt_zero) begin
            y_d    = 1'b1;
            done_d = 1'b1;
`ifdef PHASE_TIMER_AUTO_RELOAD_EN
            cnt_load = 1'b1;
`else
            state_d  = ST_DONE;
`endif
         end else begin
            cnt_dec = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         term_q  <= '0;
         y_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         term_q  <= term_d;
         y_q     <= y_d;
         done_q  <= done_d;
      end
   end

   phase_down_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .dec_i      (cnt_dec),
      .count_o    (count),
      .zero_o     (cnt_zero)
   );

   assign y          = y_q;
   assign done_pulse = done_q;
   assign busy       = (state_q == ST_RUN);

endmodule
